i2c_timer: RTL and testbench



---
 rtl/i2c_timer_pkg.sv | 21 ++
 rtl/i2c_timer_if.sv | 51 +++++
 rtl/i2c_edge_counter.sv | 38 +++
 rtl/i2c_timer.sv | 112 +++++++++++
 tb/tb_i2c_timer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_timer_pkg.sv
// Shared types and constants for the I2C slave byte-frame timer.
// Strobe positions are 1-based SCL edge numbers within an 18-edge byte frame.
package i2c_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        COUNT
    } state_e;

    localparam int unsigned COUNT_W = 5;

    localparam logic [COUNT_W-1:0] BYTE_RX   = 5'd15;
    localparam logic [COUNT_W-1:0] ACK_PREP  = 5'd16;
    localparam logic [COUNT_W-1:0] CHECK_ACK = 5'd17;
    localparam logic [COUNT_W-1:0] ACK_DONE  = 5'd18;

    localparam int unsigned KEY_BYTES = 16;
    localparam int unsigned KEY_CNT_W = $clog2(KEY_BYTES);

endpackage

// File: rtl/i2c_timer_if.sv
// Edge/condition inputs and phase strobes of the I2C byte-frame timer.
// frame_abort exists only when I2C_TIMER_ABORT_FLAG_EN is defined.
interface i2c_timer_if;

    logic rising_edge_found;
    logic falling_edge_found;
    logic stop_found;
    logic start_found;
    logic start_byte_received;
    logic byte_received;
    logic ack_prep;
    logic check_ack;
    logic ack_done;
    logic key_received;
`ifdef I2C_TIMER_ABORT_FLAG_EN
    logic frame_abort;
`endif

    modport master (
        output rising_edge_found,
        output falling_edge_found,
        output stop_found,
        output start_found,
        output start_byte_received,
        input  byte_received,
        input  ack_prep,
        input  check_ack,
        input  ack_done,
`ifdef I2C_TIMER_ABORT_FLAG_EN
        input  frame_abort,
`endif
        input  key_received
    );

    modport slave (
        input  rising_edge_found,
        input  falling_edge_found,
        input  stop_found,
        input  start_found,
        input  start_byte_received,
        output byte_received,
        output ack_prep,
        output check_ack,
        output ack_done,
`ifdef I2C_TIMER_ABORT_FLAG_EN
        output frame_abort,
`endif
        output key_received
    );

endinterface

// File: rtl/i2c_edge_counter.sv
// SCL edge counter for one byte frame: clear to 0, load to 1, step wraps WRAP -> 1.
module i2c_edge_counter
    import i2c_timer_pkg::*;
#(
    parameter int unsigned WRAP = 18
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               load,
    input  logic               step,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] WrapVal = COUNT_W'(WRAP);

    logic [COUNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = COUNT_W'(1);
        end else if (step) begin
            count_next = (count == WrapVal) ? COUNT_W'(1) : count + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/i2c_timer.sv
// I2C slave bit/byte timer: tracks SCL edges per 9-clock frame, emits ACK-phase strobes
// and flags every 16th data byte. Optional frame_abort under I2C_TIMER_ABORT_FLAG_EN.
module i2c_timer
    import i2c_timer_pkg::*;
#(
    parameter int unsigned EDGES_PER_FRAME = 18
) (
    input logic        clk,
    input logic        n_rst,
    i2c_timer_if.slave bus
);

    localparam logic [KEY_CNT_W-1:0] KeyLast = KEY_CNT_W'(KEY_BYTES - 1);

    state_e             state;
    logic [COUNT_W-1:0] count;
    logic               edge_seen;
    logic               ctr_clear;
    logic               ctr_load;
    logic               ctr_step;
    logic               stop_only;
    logic               byte_rx_q;
    logic               ack_prep_q;
    logic               check_ack_q;
    logic               ack_done_q;
    logic               key_armed;
    logic [KEY_CNT_W-1:0] key_cnt;
    logic               key_hit;
    logic               key_rx_q;

    // START outranks STOP; both outrank any edge in the same cycle.
    assign edge_seen = bus.rising_edge_found | bus.falling_edge_found;
    assign ctr_clear = bus.start_found | bus.stop_found;
    assign stop_only = bus.stop_found & ~bus.start_found;
    assign ctr_load  = (state == WAIT_RISE) & bus.rising_edge_found & ~ctr_clear;
    assign ctr_step  = (state == COUNT) & edge_seen & ~ctr_clear;

    i2c_edge_counter #(
        .WRAP(EDGES_PER_FRAME)
    ) u_edge_counter (
        .clk  (clk),
        .n_rst(n_rst),
        .clear(ctr_clear),
        .load (ctr_load),
        .step (ctr_step),
        .count(count)
    );

    // Strobes decode the pre-increment count, so they land with the new count value.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            byte_rx_q   <= 1'b0;
            ack_prep_q  <= 1'b0;
            check_ack_q <= 1'b0;
            ack_done_q  <= 1'b0;
`ifdef I2C_TIMER_ABORT_FLAG_EN
            bus.frame_abort <= 1'b0;
`endif
        end else begin
            byte_rx_q   <= ctr_step && (count == BYTE_RX - COUNT_W'(1));
            ack_prep_q  <= ctr_step && (count == ACK_PREP - COUNT_W'(1));
            check_ack_q <= ctr_step && (count == CHECK_ACK - COUNT_W'(1));
            ack_done_q  <= ctr_step && (count == ACK_DONE - COUNT_W'(1));
`ifdef I2C_TIMER_ABORT_FLAG_EN
            bus.frame_abort <= ctr_clear && (state == COUNT) && (count != ACK_DONE);
`endif
            if (bus.start_found) begin
                state <= WAIT_RISE;
            end else if (bus.stop_found) begin
                state <= IDLE;
            end else if (ctr_load) begin
                state <= COUNT;
            end
        end
    end

    assign key_hit = key_armed & ack_done_q & (key_cnt == KeyLast) & ~ctr_clear &
                     ~bus.start_byte_received;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            key_armed <= 1'b0;
            key_cnt   <= '0;
            key_rx_q  <= 1'b0;
        end else begin
            if (ctr_clear) begin
                key_armed <= 1'b0;
            end else if (bus.start_byte_received) begin
                key_armed <= 1'b1;
                key_cnt   <= '0;
            end else if (key_armed && ack_done_q) begin
                key_cnt <= key_cnt + KEY_CNT_W'(1);
            end

            if (stop_only) begin
                key_rx_q <= 1'b0;
            end else if (key_hit) begin
                key_rx_q <= 1'b1;
            end else if (bus.rising_edge_found) begin
                key_rx_q <= 1'b0;
            end
        end
    end

    assign bus.byte_received = byte_rx_q;
    assign bus.ack_prep      = ack_prep_q;
    assign bus.check_ack     = check_ack_q;
    assign bus.ack_done      = ack_done_q;
    assign bus.key_received  = key_rx_q;

endmodule

// File: tb/tb_i2c_timer.sv
// Bench for i2c_timer: directed frame sequences plus random edge/condition traffic,
// every cycle compared against a frame-position reference model.
module tb_i2c_timer;

    localparam int FRAME_EDGES = 18;
    localparam int KEY_LEN     = 16;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    i2c_timer_if bus ();

    i2c_timer #(
        .EDGES_PER_FRAME(18)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 waiting for first rise, 2 inside a frame at edge m_pos.
    int m_mode;
    int m_pos;
    bit m_armed;
    int m_bytes;
    bit m_key;
    bit m_br, m_ap, m_ca, m_ack, m_abort;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_armed = 0; m_bytes = 0; m_key = 0;
        m_br = 0; m_ap = 0; m_ca = 0; m_ack = 0; m_abort = 0;
    endtask

    task automatic model_cycle(input bit r, input bit f, input bit st, input bit sp,
                               input bit sb);
        bit old_ack;
        bit key_set;
        bit adv;
        old_ack = m_ack;
        key_set = 0;
        adv     = 0;
        m_br = 0; m_ap = 0; m_ca = 0; m_ack = 0; m_abort = 0;
        if (st || sp) begin
            m_abort = (m_mode == 2) && (m_pos != FRAME_EDGES);
            m_pos   = 0;
            m_armed = 0;
            if (st) begin
                m_mode = 1;
                if (r) m_key = 0;
            end else begin
                m_mode = 0;
                m_key  = 0;
            end
        end else begin
            if (sb) begin
                m_armed = 1;
                m_bytes = 0;
            end else if (m_armed && old_ack) begin
                m_bytes++;
                key_set = (m_bytes % KEY_LEN) == 0;
            end
            if (key_set) m_key = 1;
            else if (r) m_key = 0;

            if (m_mode == 1 && r) begin
                m_mode = 2;
                m_pos  = 1;
                adv    = 1;
            end else if (m_mode == 2 && (r || f)) begin
                m_pos = (m_pos % FRAME_EDGES) + 1;
                adv   = 1;
            end
            if (adv) begin
                m_br  = (m_pos == 15);
                m_ap  = (m_pos == 16);
                m_ca  = (m_pos == 17);
                m_ack = (m_pos == 18);
            end
        end
    endtask

    task automatic check_outputs();
        chk("byte_received", bus.byte_received, m_br);
        chk("ack_prep", bus.ack_prep, m_ap);
        chk("check_ack", bus.check_ack, m_ca);
        chk("ack_done", bus.ack_done, m_ack);
        chk("key_received", bus.key_received, m_key);
`ifdef I2C_TIMER_ABORT_FLAG_EN
        chk("frame_abort", bus.frame_abort, m_abort);
`endif
    endtask

    task automatic step(input bit r, input bit f, input bit st, input bit sp, input bit sb);
        bus.rising_edge_found   = r;
        bus.falling_edge_found  = f;
        bus.start_found         = st;
        bus.stop_found          = sp;
        bus.start_byte_received = sb;
        model_cycle(r, f, st, sp, sb);
        @(posedge clk);
        #1;
        bus.rising_edge_found   = 1'b0;
        bus.falling_edge_found  = 1'b0;
        bus.start_found         = 1'b0;
        bus.stop_found          = 1'b0;
        bus.start_byte_received = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Alternating rising/falling edges, starting with a rising edge.
    task automatic run_edges(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) step(1, 0, 0, 0, 0);
            else            step(0, 1, 0, 0, 0);
            idle(gap);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_byte_received"}, bus.byte_received, 1'b0);
        chk({tag, "_ack_prep"}, bus.ack_prep, 1'b0);
        chk({tag, "_check_ack"}, bus.check_ack, 1'b0);
        chk({tag, "_ack_done"}, bus.ack_done, 1'b0);
        chk({tag, "_key_received"}, bus.key_received, 1'b0);
    endtask

    initial begin
        bus.rising_edge_found   = 1'b0;
        bus.falling_edge_found  = 1'b0;
        bus.start_found         = 1'b0;
        bus.stop_found          = 1'b0;
        bus.start_byte_received = 1'b0;
        model_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");
        n_rst = 1'b1;
        idle(3);

        // 100 full frames.
        step(0, 0, 1, 0, 0);
        idle(5);
        run_edges(FRAME_EDGES * 100, 5);
        step(0, 0, 0, 1, 0);
        idle(3);
        all_zero("after_stop");

        // Partial frame then double STOP: no strobes.
        step(0, 0, 1, 0, 0);
        idle(5);
        run_edges(14, 5);
        step(0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 1, 0);
        idle(3);
        all_zero("double_stop");

        // Leading falling edge before first rise is ignored.
        step(0, 0, 1, 0, 0);
        idle(5);
        step(0, 1, 0, 0, 0);
        idle(5);
        run_edges(FRAME_EDGES * 10, 5);
        step(0, 0, 0, 1, 0);
        idle(3);

        // Address frame, arm key mode, 50 data frames.
        step(0, 0, 1, 0, 0);
        idle(5);
        run_edges(FRAME_EDGES, 5);
        step(0, 0, 0, 0, 1);
        idle(5);
        for (int k = 1; k <= 50; k++) begin
            run_edges(FRAME_EDGES, 5);
            chk("key_after_frame", bus.key_received, (k % KEY_LEN) == 0);
        end
        step(0, 0, 0, 1, 0);
        idle(3);
        all_zero("key_stop");

        // Repeated START mid-frame realigns the frame.
        step(0, 0, 1, 0, 0);
        idle(5);
        run_edges(FRAME_EDGES * 3 + 9, 5);
        step(0, 0, 1, 0, 0);
        idle(5);
        run_edges(FRAME_EDGES * 2, 5);
        step(0, 0, 0, 1, 0);
        idle(3);

        // STOP mid-frame, then STOP right after a complete frame.
        step(0, 0, 1, 0, 0);
        idle(5);
        run_edges(9, 5);
        step(0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 1, 0, 0);
        idle(5);
        run_edges(FRAME_EDGES, 5);
        step(0, 0, 0, 1, 0);
        idle(3);

        // Armed key traffic with random gaps and occasional simultaneous edges.
        step(0, 0, 1, 0, 0);
        idle(2);
        run_edges(FRAME_EDGES, 2);
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < FRAME_EDGES * 20; k++) begin
            bit both;
            both = ($urandom_range(0, 15) == 0);
            if (k % 2 == 0) step(1, both, 0, 0, 0);
            else            step(both, 1, 0, 0, 0);
            idle($urandom_range(1, 6));
        end

        // Fully random pulse traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, f, st, sp, sb;
            r  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 149) == 0);
            sp = ($urandom_range(0, 149) == 0);
            sb = ($urandom_range(0, 99) == 0);
            step(r, f, st, sp, sb);
        end
        step(0, 0, 0, 1, 0);
        idle(3);
        all_zero("final_stop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
